// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL lock supervisor and staggered per-domain reset sequencer.
// Optional build macro PLL_TIMEOUT_EN adds a lock timeout that pulses pll_rst.
module pll_lock_seq #(
  parameter int NUM_CH      = 4,
  parameter int FILTER_CYC  = 1024,
  parameter int STAGGER_CYC = 16,
  parameter int HOLD_CYC    = 64,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 65536,
  parameter int PLLRST_CYC  = 32
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              pll_lock,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ready,
  output logic [CNT_W-1:0]  loss_cnt,
  output logic              pll_rst,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4,
    PLLRST    = 3'd5
  } state_t;

  localparam int FW = $clog2(FILTER_CYC + 1);
  localparam int SW = $clog2(STAGGER_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [FW-1:0] FILT_MAX  = FW'(FILTER_CYC);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 16 || FILTER_CYC < 1 || STAGGER_CYC < 1 ||
      HOLD_CYC < 1 || CNT_W < 1 || TIMEOUT_CYC < 1 || PLLRST_CYC < 1) begin : g_bad_param
    $error("pll_lock_seq: parameter out of range");
  end

  state_t cur, nxt;
  logic [1:0]        sync;
  logic              lock_s;
  logic [FW-1:0]     filt_cnt, filt_nxt;
  logic [SW-1:0]     stag_cnt, stag_nxt;
  logic [CW-1:0]     ch_idx, ch_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [NUM_CH-1:0] rst_nxt;
  logic              ready_nxt;
  logic [CNT_W-1:0]  loss_nxt;

`ifdef PLL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(PLLRST_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] PR_LAST = PW'(PLLRST_CYC - 1);

  logic [TW-1:0] to_cnt, to_nxt;
  logic [PW-1:0] pr_cnt, pr_nxt;
  logic          pll_rst_nxt;
`endif

  assign lock_s = sync[1];
  assign state  = cur;

  always_comb begin
    nxt       = cur;
    rst_nxt   = rst_out;
    ready_nxt = ready;
    loss_nxt  = loss_cnt;
    filt_nxt  = filt_cnt;
    stag_nxt  = stag_cnt;
    ch_nxt    = ch_idx;
    hold_nxt  = hold_cnt;
`ifdef PLL_TIMEOUT_EN
    to_nxt      = to_cnt;
    pr_nxt      = pr_cnt;
    pll_rst_nxt = pll_rst;
`endif

    case (cur)
      WAIT_LOCK: begin
        rst_nxt   = '1;
        ready_nxt = 1'b0;
        if (lock_s) begin
          nxt      = FILTER;
          filt_nxt = FW'(1);
        end
      end

      FILTER: begin
        if (!lock_s) begin
          nxt      = WAIT_LOCK;
          filt_nxt = '0;
        end else if (filt_cnt == FILT_MAX) begin
          filt_nxt   = '0;
          stag_nxt   = '0;
          ch_nxt     = CW'(1);
          rst_nxt[0] = 1'b0;
          if (NUM_CH == 1) begin
            ready_nxt = 1'b1;
            nxt       = RUN;
          end else begin
            nxt = RELEASE;
          end
        end else begin
          filt_nxt = filt_cnt + 1'b1;
        end
      end

      // Lock loss wins over a channel release due on the same edge.
      RELEASE, RUN: begin
        if (!lock_s) begin
          nxt       = HOLD;
          rst_nxt   = '1;
          ready_nxt = 1'b0;
          hold_nxt  = '0;
          if (loss_cnt != {CNT_W{1'b1}}) loss_nxt = loss_cnt + 1'b1;
        end else if (cur == RELEASE) begin
          if (stag_cnt == STAG_LAST) begin
            stag_nxt        = '0;
            rst_nxt[ch_idx] = 1'b0;
            if (ch_idx == LAST_CH) begin
              ready_nxt = 1'b1;
              nxt       = RUN;
            end else begin
              ch_nxt = ch_idx + 1'b1;
            end
          end else begin
            stag_nxt = stag_cnt + 1'b1;
          end
        end
      end

      HOLD: begin
        rst_nxt   = '1;
        ready_nxt = 1'b0;
        if (hold_cnt == HOLD_LAST) nxt = WAIT_LOCK;
        else hold_nxt = hold_cnt + 1'b1;
      end

`ifdef PLL_TIMEOUT_EN
      PLLRST: begin
        rst_nxt   = '1;
        ready_nxt = 1'b0;
        if (pr_cnt == PR_LAST) begin
          nxt         = WAIT_LOCK;
          pll_rst_nxt = 1'b0;
        end else begin
          pr_nxt = pr_cnt + 1'b1;
        end
      end
`endif

      default: begin
        nxt       = WAIT_LOCK;
        rst_nxt   = '1;
        ready_nxt = 1'b0;
      end
    endcase

`ifdef PLL_TIMEOUT_EN
    // A lock that completes filtering on the timeout edge is still honoured.
    if (cur == WAIT_LOCK || cur == FILTER) begin
      if (nxt == RELEASE || nxt == RUN) begin
        to_nxt = '0;
      end else if (to_cnt == TO_LAST) begin
        nxt         = PLLRST;
        to_nxt      = '0;
        pr_nxt      = '0;
        pll_rst_nxt = 1'b1;
        filt_nxt    = '0;
      end else begin
        to_nxt = to_cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync     <= '0;
      cur      <= WAIT_LOCK;
      rst_out  <= '1;
      ready    <= 1'b0;
      loss_cnt <= '0;
      filt_cnt <= '0;
      stag_cnt <= '0;
      ch_idx   <= '0;
      hold_cnt <= '0;
    end else begin
      sync     <= {sync[0], pll_lock};
      cur      <= nxt;
      rst_out  <= rst_nxt;
      ready    <= ready_nxt;
      loss_cnt <= loss_nxt;
      filt_cnt <= filt_nxt;
      stag_cnt <= stag_nxt;
      ch_idx   <= ch_nxt;
      hold_cnt <= hold_nxt;
    end
  end

`ifdef PLL_TIMEOUT_EN
  always_ff @(posedge clkin) begin
    if (reset) begin
      to_cnt  <= '0;
      pr_cnt  <= '0;
      pll_rst <= 1'b0;
    end else begin
      to_cnt  <= to_nxt;
      pr_cnt  <= pr_nxt;
      pll_rst <= pll_rst_nxt;
    end
  end
`else
  assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: scenario bench for pll_lock_seq; expected samples are queued
// per edge from the documented release/loss/hold timing and compared at negedge.
module tb_pll_lock_seq;

  localparam int NUM_CH      = 3;
  localparam int FILTER_CYC  = 8;
  localparam int STAGGER_CYC = 4;
  localparam int HOLD_CYC    = 5;
  localparam int CNT_W       = 2;
  localparam int TIMEOUT_CYC = 20;
  localparam int PLLRST_CYC  = 3;

  logic              clkin = 1'b0;
  logic              reset;
  logic              pll_lock;
  logic [NUM_CH-1:0] rst_out;
  logic              ready;
  logic [CNT_W-1:0]  loss_cnt;
  logic              pll_rst;
  logic [2:0]        state;

  pll_lock_seq #(
    .NUM_CH(NUM_CH), .FILTER_CYC(FILTER_CYC), .STAGGER_CYC(STAGGER_CYC),
    .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC),
    .PLLRST_CYC(PLLRST_CYC)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .rst_out(rst_out),
    .ready(ready), .loss_cnt(loss_cnt), .pll_rst(pll_rst), .state(state)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int         at;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] loss;
    logic [2:0] st;
    logic       prst;
  } exp_t;

  exp_t sb[$];
  int   edge_no;
  int   total = 0;
  int   bad   = 0;

  function automatic void expect_at(int at, logic [2:0] r, logic rd, logic [1:0] l,
                                    logic [2:0] s, logic p);
    exp_t e;
    e.at = at; e.rst = r; e.rdy = rd; e.loss = l; e.st = s; e.prst = p;
    sb.push_back(e);
  endfunction

  // Drive inputs at the falling edge, take one rising edge, return at the next falling edge.
  task automatic step(input logic lock, input logic rst_in);
    pll_lock = lock;
    reset    = rst_in;
    @(posedge clkin);
    edge_no++;
    @(negedge clkin);
  endtask

  task automatic test_reset();
    exp_t e;
    edge_no = 0;
    expect_at(1, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(2, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      step(1'b1, 1'b1);
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        total++;
        if ({rst_out, ready, loss_cnt, state, pll_rst} !== {e.rst, e.rdy, e.loss, e.st, e.prst}) begin
          bad++;
          $display("[TB] FAIL reset edge %0d: got rst_out=%b ready=%b loss_cnt=%0d state=%0d pll_rst=%b, want %b %b %0d %0d %b",
                   edge_no, rst_out, ready, loss_cnt, state, pll_rst, e.rst, e.rdy, e.loss, e.st, e.prst);
        end
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++; bad++;
      $display("[TB] FAIL reset edge %0d: sample never reached", e.at);
    end
  endtask

  task automatic test_clean_lock();
    exp_t e;
    step(1'b0, 1'b1);
    edge_no = -1;
    expect_at(1,  3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(2,  3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(9,  3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(10, 3'b110, 1'b0, 2'd0, 3'd2, 1'b0);
    expect_at(13, 3'b110, 1'b0, 2'd0, 3'd2, 1'b0);
    expect_at(14, 3'b100, 1'b0, 2'd0, 3'd2, 1'b0);
    expect_at(17, 3'b100, 1'b0, 2'd0, 3'd2, 1'b0);
    expect_at(18, 3'b000, 1'b1, 2'd0, 3'd3, 1'b0);
    expect_at(25, 3'b000, 1'b1, 2'd0, 3'd3, 1'b0);
    for (int k = 0; k <= 25; k++) begin
      step(1'b1, 1'b0);
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        total++;
        if ({rst_out, ready, loss_cnt, state, pll_rst} !== {e.rst, e.rdy, e.loss, e.st, e.prst}) begin
          bad++;
          $display("[TB] FAIL clean_lock edge %0d: got rst_out=%b ready=%b loss_cnt=%0d state=%0d pll_rst=%b, want %b %b %0d %0d %b",
                   edge_no, rst_out, ready, loss_cnt, state, pll_rst, e.rst, e.rdy, e.loss, e.st, e.prst);
        end
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++; bad++;
      $display("[TB] FAIL clean_lock edge %0d: sample never reached", e.at);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    step(1'b0, 1'b1);
    edge_no = -1;
    expect_at(5,  3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(6,  3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(7,  3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(8,  3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(15, 3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(16, 3'b110, 1'b0, 2'd0, 3'd2, 1'b0);
    expect_at(24, 3'b000, 1'b1, 2'd0, 3'd3, 1'b0);
    for (int k = 0; k <= 24; k++) begin
      step((k < 5) || (k >= 6), 1'b0);
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        total++;
        if ({rst_out, ready, loss_cnt, state, pll_rst} !== {e.rst, e.rdy, e.loss, e.st, e.prst}) begin
          bad++;
          $display("[TB] FAIL glitch edge %0d: got rst_out=%b ready=%b loss_cnt=%0d state=%0d pll_rst=%b, want %b %b %0d %0d %b",
                   edge_no, rst_out, ready, loss_cnt, state, pll_rst, e.rst, e.rdy, e.loss, e.st, e.prst);
        end
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++; bad++;
      $display("[TB] FAIL glitch edge %0d: sample never reached", e.at);
    end
  endtask

  // Lock is first sampled low at edge 23 and high again from edge 30.
  task automatic test_loss_run();
    exp_t e;
    step(1'b0, 1'b1);
    edge_no = -1;
    expect_at(24, 3'b000, 1'b1, 2'd0, 3'd3, 1'b0);
    expect_at(25, 3'b111, 1'b0, 2'd1, 3'd4, 1'b0);
    expect_at(29, 3'b111, 1'b0, 2'd1, 3'd4, 1'b0);
    expect_at(30, 3'b111, 1'b0, 2'd1, 3'd0, 1'b0);
    expect_at(31, 3'b111, 1'b0, 2'd1, 3'd0, 1'b0);
    expect_at(32, 3'b111, 1'b0, 2'd1, 3'd1, 1'b0);
    expect_at(39, 3'b111, 1'b0, 2'd1, 3'd1, 1'b0);
    expect_at(40, 3'b110, 1'b0, 2'd1, 3'd2, 1'b0);
    expect_at(44, 3'b100, 1'b0, 2'd1, 3'd2, 1'b0);
    expect_at(48, 3'b000, 1'b1, 2'd1, 3'd3, 1'b0);
    for (int k = 0; k <= 48; k++) begin
      step((k < 23) || (k >= 30), 1'b0);
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        total++;
        if ({rst_out, ready, loss_cnt, state, pll_rst} !== {e.rst, e.rdy, e.loss, e.st, e.prst}) begin
          bad++;
          $display("[TB] FAIL loss_run edge %0d: got rst_out=%b ready=%b loss_cnt=%0d state=%0d pll_rst=%b, want %b %b %0d %0d %b",
                   edge_no, rst_out, ready, loss_cnt, state, pll_rst, e.rst, e.rdy, e.loss, e.st, e.prst);
        end
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++; bad++;
      $display("[TB] FAIL loss_run edge %0d: sample never reached", e.at);
    end
  endtask

  // Continues from the RUN state left by test_loss_run (loss_cnt=1).
  task automatic test_reset_run();
    exp_t e;
    expect_at(49, 3'b000, 1'b1, 2'd1, 3'd3, 1'b0);
    expect_at(50, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(51, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(52, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(53, 3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(60, 3'b111, 1'b0, 2'd0, 3'd1, 1'b0);
    expect_at(61, 3'b110, 1'b0, 2'd0, 3'd2, 1'b0);
    for (int k = 49; k <= 61; k++) begin
      step(1'b1, k == 50);
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        total++;
        if ({rst_out, ready, loss_cnt, state, pll_rst} !== {e.rst, e.rdy, e.loss, e.st, e.prst}) begin
          bad++;
          $display("[TB] FAIL reset_run edge %0d: got rst_out=%b ready=%b loss_cnt=%0d state=%0d pll_rst=%b, want %b %b %0d %0d %b",
                   edge_no, rst_out, ready, loss_cnt, state, pll_rst, e.rst, e.rdy, e.loss, e.st, e.prst);
        end
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++; bad++;
      $display("[TB] FAIL reset_run edge %0d: sample never reached", e.at);
    end
  endtask

  // Each 23-edge round: lock high 16 edges, loss lands mid-RELEASE, then HOLD.
  task automatic test_loss_release();
    exp_t e;
    int   b;
    step(1'b0, 1'b1);
    edge_no = -1;
    for (int i = 0; i < 4; i++) begin
      b = 23 * i;
      expect_at(b + 17, 3'b100, 1'b0, (i     > 3) ? 2'd3 : 2'(i),     3'd2, 1'b0);
      expect_at(b + 18, 3'b111, 1'b0, (i + 1 > 3) ? 2'd3 : 2'(i + 1), 3'd4, 1'b0);
      expect_at(b + 22, 3'b111, 1'b0, (i + 1 > 3) ? 2'd3 : 2'(i + 1), 3'd4, 1'b0);
      expect_at(b + 23, 3'b111, 1'b0, (i + 1 > 3) ? 2'd3 : 2'(i + 1), 3'd0, 1'b0);
    end
    for (int k = 0; k <= 92; k++) begin
      step((k % 23) < 16, 1'b0);
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        total++;
        if ({rst_out, ready, loss_cnt, state, pll_rst} !== {e.rst, e.rdy, e.loss, e.st, e.prst}) begin
          bad++;
          $display("[TB] FAIL loss_release edge %0d: got rst_out=%b ready=%b loss_cnt=%0d state=%0d pll_rst=%b, want %b %b %0d %0d %b",
                   edge_no, rst_out, ready, loss_cnt, state, pll_rst, e.rst, e.rdy, e.loss, e.st, e.prst);
        end
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++; bad++;
      $display("[TB] FAIL loss_release edge %0d: sample never reached", e.at);
    end
  endtask

  // Edges counted from the reset edge as edge 0; pll_lock never rises.
  task automatic test_timeout();
    exp_t e;
    step(1'b0, 1'b1);
    edge_no = 0;
`ifdef PLL_TIMEOUT_EN
    expect_at(1,  3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(19, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(20, 3'b111, 1'b0, 2'd0, 3'd5, 1'b1);
    expect_at(21, 3'b111, 1'b0, 2'd0, 3'd5, 1'b1);
    expect_at(22, 3'b111, 1'b0, 2'd0, 3'd5, 1'b1);
    expect_at(23, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
    expect_at(24, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
`else
    for (int k = 1; k <= 30; k++) expect_at(k, 3'b111, 1'b0, 2'd0, 3'd0, 1'b0);
`endif
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b0);
      while (sb.size() > 0 && sb[0].at == edge_no) begin
        e = sb.pop_front();
        total++;
        if ({rst_out, ready, loss_cnt, state, pll_rst} !== {e.rst, e.rdy, e.loss, e.st, e.prst}) begin
          bad++;
          $display("[TB] FAIL timeout edge %0d: got rst_out=%b ready=%b loss_cnt=%0d state=%0d pll_rst=%b, want %b %b %0d %0d %b",
                   edge_no, rst_out, ready, loss_cnt, state, pll_rst, e.rst, e.rdy, e.loss, e.st, e.prst);
        end
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++; bad++;
      $display("[TB] FAIL timeout edge %0d: sample never reached", e.at);
    end
  endtask

  initial begin
    $display("[TB] pll_lock_seq bench start");
    test_reset();
    test_clean_lock();
    test_glitch();
    test_loss_run();
    test_reset_run();
    test_loss_release();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
